// File: rtl/cbus_rr_arbiter_pkg.sv
// cbus_rr_arbiter_pkg: shared cache-bus request/response types and the arbiter state encoding.
package cbus_rr_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  len;
        logic [3:0]  strobe;
        logic [31:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/cbus_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   valid : per-requester request flags
//   ptr   : index with highest priority this round
//   found : at least one valid
//   idx   : first valid index scanning ptr, ptr+1, ... with wrap
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // Wrap is compare-and-clear so non-power-of-two N stays correct.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = ptr;
        for (int k = 0; k < N; k++) begin
            if (!found && valid[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
            cand = (cand == IDX_W'(N - 1)) ? '0 : cand + IDX_W'(1);
        end
    end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: transaction-locked round-robin arbiter for the shared cache bus.
//   clk, resetn : clock, synchronous active-low reset
//   ireqs       : requests (0 = DCache, 1 = ICache, 2 = uncached)
//   iresps      : responses, zero for every non-granted requester
//   oreq, oresp : downstream bus request/response
//   busy        : a grant is active
//   grant_idx   : current or last granted requester
module cbus_rr_arbiter
    import cbus_rr_arbiter_pkg::*;
#(
    parameter  int NUM_INPUTS = 3,
    localparam int IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  cbus_req_t  [NUM_INPUTS-1:0]   ireqs,
    output cbus_resp_t [NUM_INPUTS-1:0]   iresps,
    output cbus_req_t                     oreq,
    input  cbus_resp_t                    oresp,
    output logic                          busy,
    output logic       [IDX_W-1:0]        grant_idx
);

    arb_state_t             state, next_state;
    logic [IDX_W-1:0]       ptr, pick_idx;
    logic [NUM_INPUTS-1:0]  valids;
    logic                   found, done;

    always_comb begin
        valids = '0;
        for (int i = 0; i < NUM_INPUTS; i++) valids[i] = ireqs[i].valid;
    end

    rr_pick #(.N(NUM_INPUTS), .IDX_W(IDX_W)) u_pick (
        .valid (valids),
        .ptr   (ptr),
        .found (found),
        .idx   (pick_idx)
    );

    assign done = oresp.ready & oresp.last;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_idx <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && found) grant_idx <= pick_idx;
            // Priority moves to the requester after the one just served.
            if (state == BUSY && done)
                ptr <= (grant_idx == IDX_W'(NUM_INPUTS - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    always_comb
        next_state = (state == IDLE) ? (found ? BUSY : IDLE) : (done ? IDLE : BUSY);

    always_comb begin
        oreq   = '0;
        iresps = '0;
        if (state == BUSY) begin
            oreq              = ireqs[grant_idx];
            iresps[grant_idx] = oresp;
        end
    end

    assign busy = (state == BUSY);

endmodule

// File: doc/cbus_rr_arbiter.md
# cbus_rr_arbiter

Round-robin, transaction-locked arbiter sharing the single cache bus (cbus) between the ICache, DCache and an uncached-access port inside the cache manager. It grants one requester at a time. It holds the grant until the granted burst completes (`ready & last`), then rotates priority so no requester starves. It returns zero responses to every non-granted requester.

## Interface
- `NUM_INPUTS`, 3: number of requesters; index 0 = DCache, 1 = ICache, 2 = uncached port.
- `IDX_W`, `$clog2(NUM_INPUTS)`: grant index width; derived, not overridden.
- `clk` in 1: single clock.
- `resetn` in 1: synchronous, active-low reset.
- `ireqs` in `cbus_req_t [NUM_INPUTS-1:0]`: requester requests; each held stable from `valid` until its last beat.
- `iresps` out `cbus_resp_t [NUM_INPUTS-1:0]`: per-requester responses; all-zero unless that requester is granted.
- `oreq` out `cbus_req_t`: request to the downstream bus.
- `oresp` in `cbus_resp_t`: downstream response (`ready`, `last`, `data`).
- `busy` out 1: a grant is active; debug/perf only.
- `grant_idx` out `IDX_W`: index of the current or last granted requester.

## Operation
- FSM states: `IDLE` and `BUSY`.
- In `IDLE`: `oreq` is all-zero. If any `ireqs[i].valid`, select the first valid index scanning `ptr, ptr+1, …` modulo `NUM_INPUTS`. Register it into `grant_idx` and go to `BUSY`.
- In `BUSY`: `oreq = ireqs[grant_idx]`, `iresps[grant_idx] = oresp`, and all other `iresps` are zero.
- Exit `BUSY` when `oresp.ready & oresp.last`. Return to `IDLE` and set `ptr = (grant_idx + 1) mod NUM_INPUTS`.
- Granted requester deasserts `valid` before last: protocol violation. The arbiter stays in `BUSY` and forwards the request as-is. The bench flags this with an assertion; the RTL does not recover.
- New requests arriving during `BUSY` are ignored until the return to `IDLE`. Requesters keep `valid` high and see zero responses meanwhile.
- Pointer wrap: `ptr = NUM_INPUTS-1` with grant at `NUM_INPUTS-1` wraps to 0. Modulo is implemented by compare-and-clear, not `%`, so non-power-of-two `NUM_INPUTS` is correct.

## Timing
- Reset (synchronous, `resetn=0` at a rising edge): state `IDLE`, `ptr=0`, `grant_idx=0`, `busy=0`, `oreq` zero, all `iresps` zero.
- Reset mid-burst aborts the transaction with no last beat delivered. Upstream caches reset on the same `resetn`.
- Arbitration latency is one cycle:
  - `valid` sampled in `IDLE` at edge N.
  - `oreq.valid` is visible after edge N, combinationally in cycle N+1.
- `oreq` and `iresps` are combinational from the registered state and the inputs; no extra pipeline stage.
- Turnaround: after the last-beat edge the FSM is in `IDLE` for exactly one cycle before the next grant. Minimum gap between back-to-back bursts is one idle cycle.
- Simultaneous events:
  - In `IDLE`, multiple valids resolve by `ptr` order within that cycle.
  - A last beat and a new `valid` in the same cycle: the new request is arbitrated in the following `IDLE` cycle using the updated `ptr`.
- `busy = (state == BUSY)`.

## Structure
- `cbus_req_t` and `cbus_resp_t` already live in the common package. Add `arb_state_t` (`IDLE`, `BUSY`) there as well.
- One natural sub-module: `rr_pick`. It is combinational and maps `valid[NUM_INPUTS-1:0]` and `ptr` to `found` and `idx`. It is reusable for future multi-port arbiters.
- Top holds the FSM, `ptr` and `grant_idx` registers, and the response demux.

## Test plan
- Reset, then idle: with `resetn` low for 2 cycles, then all valids 0 for 5 cycles → `oreq.valid=0`, `busy=0`, all `iresps` zero throughout.
- Single DCache burst: `ireqs[0].valid=1`, `len=3`, downstream returns `ready` on 4 beats with `last` on the 4th → `oreq.valid=1` one cycle after the request. `iresps[0]` mirrors all 4 beats. `ptr=1` afterwards.
- Three-way contention: all three valid from reset, each burst of 2 beats → grant order 0,1,2,0. Each requester sees zero responses while not granted. One idle cycle separates grants.
- Wrap-around: with `ptr=2`, requesters 0 and 2 valid → grant 2 first, then `ptr=0`, and grant 0 next.
- Hold during wait: downstream stalls `ready=0` for 10 cycles mid-burst while requester 1 asserts valid → grant stays on the current requester and `iresps[1]` stays zero.
- Reset mid-burst: assert `resetn=0` after beat 2 of 4 → next cycle `IDLE`, `oreq.valid=0`, `ptr=0`. The first post-reset grant goes to the lowest valid index.
